// File: rtl/lipsi_acc_alu_pkg.sv
// ---------------------------------------------------------------------------
// lipsi_acc_pkg
// Shared definitions for the LIPSI accumulator/ALU:
//   - op_e        : 4-bit operation encodings driven on the op bus
//   - state_e     : control FSM states (IDLE, SHIFT)
//   - is_shift_op : true for the multi-cycle shift/rotate operations
// ---------------------------------------------------------------------------
package lipsi_acc_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_LD  = 4'd1,
    OP_ADD = 4'd2,
    OP_ADC = 4'd3,
    OP_SUB = 4'd4,
    OP_SBC = 4'd5,
    OP_AND = 4'd6,
    OP_OR  = 4'd7,
    OP_XOR = 4'd8,
    OP_SHL = 4'd9,
    OP_SHR = 4'd10,
    OP_ROL = 4'd11,
    OP_ROR = 4'd12,
    OP_CLR = 4'd13
  } op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Shift and rotate ops are the only ones that may take more than one edge.
  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/lipsi_acc_alu_if.sv
// ---------------------------------------------------------------------------
// lipsi_acc_alu_if
// Request/response bundle between the LIPSI control FSM and the accumulator.
//   master (control FSM): drives start, op, operand, shamt;
//                         observes ready, done, acc_out, carry, zero
//   slave  (accumulator): the opposite directions
// ---------------------------------------------------------------------------
interface lipsi_acc_alu_if #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH) + 1
);

  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] operand;
  logic [SHW-1:0]   shamt;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] acc_out;
  logic             carry;
  logic             zero;

  modport master (
    output start, op, operand, shamt,
    input  ready, done, acc_out, carry, zero
  );

  modport slave (
    input  start, op, operand, shamt,
    output ready, done, acc_out, carry, zero
  );

endinterface

// File: rtl/lipsi_acc_alu_addsub.sv
// ---------------------------------------------------------------------------
// lipsi_acc_addsub
// Combinational WIDTH-bit adder/subtractor shared by ADD/ADC/SUB/SBC.
//   a_i, b_i : operands
//   cin_i    : carry-in (add) or borrow-in (subtract)
//   sub_i    : 1 selects a_i - b_i - cin_i, 0 selects a_i + b_i + cin_i
//   sum_o    : result modulo 2^WIDTH
//   cout_o   : carry-out (add) or borrow-out (subtract)
// ---------------------------------------------------------------------------
module lipsi_acc_addsub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  logic [WIDTH:0] res;

  // One extra bit holds the carry on add; on subtract the result is negative
  // (a borrow happened) exactly when that extra bit comes out set.
  always_comb begin
    if (sub_i) begin
      res = {1'b0, a_i} - {1'b0, b_i} - {{WIDTH{1'b0}}, cin_i};
    end else begin
      res = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};
    end
  end

  assign sum_o  = res[WIDTH-1:0];
  assign cout_o = res[WIDTH];

endmodule

// File: rtl/lipsi_acc_alu.sv
// ---------------------------------------------------------------------------
// lipsi_acc_alu
// Accumulator with integrated ALU, carry/zero flags and a one-bit-per-cycle
// shifter for the LIPSI core.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : slave side of lipsi_acc_alu_if (start/op/operand/shamt in,
//             ready/done/acc_out/carry/zero out)
// ---------------------------------------------------------------------------
module lipsi_acc_alu
  import lipsi_acc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  lipsi_acc_alu_if.slave bus
);

  localparam logic [SHW-1:0] SHMAX = SHW'(WIDTH);
  localparam logic [SHW-1:0] ONE   = SHW'(1);

  state_e           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [3:0]       shOp_q, shOp_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;
  logic             writesAcc;

  logic [WIDTH-1:0] asSum;
  logic             asCarry;
  logic             asSub;
  logic             asCin;

  // The arithmetic unit is steered straight from the op bus; its result is
  // only consumed on an edge where an arithmetic op is accepted.
  assign asSub = (bus.op == OP_SUB) || (bus.op == OP_SBC);
  assign asCin = ((bus.op == OP_ADC) || (bus.op == OP_SBC)) ? carry_q : 1'b0;

  lipsi_acc_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a_i   (acc_q),
    .b_i   (bus.operand),
    .cin_i (asCin),
    .sub_i (asSub),
    .sum_o (asSum),
    .cout_o(asCarry)
  );

  // Next-state and datapath. In IDLE an accepted op either executes right
  // away or, for a non-zero shift, loads the step counter (saturated at
  // WIDTH) and latches the shift op. In SHIFT each edge moves the
  // accumulator one bit; the step that takes the counter to zero finishes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shOp_d    = shOp_q;
    acc_d     = acc_q;
    carry_d   = carry_q;
    done_d    = 1'b0;
    writesAcc = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (is_shift_op(bus.op) && (bus.shamt != '0)) begin
            state_d = SHIFT;
            shOp_d  = bus.op;
            cnt_d   = (bus.shamt > SHMAX) ? SHMAX : bus.shamt;
          end else begin
            done_d = 1'b1;
            case (bus.op)
              OP_LD: begin
                acc_d     = bus.operand;
                writesAcc = 1'b1;
              end
              OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
                acc_d     = asSum;
                carry_d   = asCarry;
                writesAcc = 1'b1;
              end
              OP_AND: begin
                acc_d     = acc_q & bus.operand;
                writesAcc = 1'b1;
              end
              OP_OR: begin
                acc_d     = acc_q | bus.operand;
                writesAcc = 1'b1;
              end
              OP_XOR: begin
                acc_d     = acc_q ^ bus.operand;
                writesAcc = 1'b1;
              end
              OP_CLR: begin
                acc_d     = '0;
                carry_d   = 1'b0;
                writesAcc = 1'b1;
              end
              default: begin
              end
            endcase
          end
        end
      end

      SHIFT: begin
        writesAcc = 1'b1;
        case (shOp_q)
          OP_SHL: begin
            acc_d   = {acc_q[WIDTH-2:0], 1'b0};
            carry_d = acc_q[WIDTH-1];
          end
          OP_SHR: begin
            acc_d   = {1'b0, acc_q[WIDTH-1:1]};
            carry_d = acc_q[0];
          end
          OP_ROL: begin
            acc_d   = {acc_q[WIDTH-2:0], acc_q[WIDTH-1]};
            carry_d = acc_q[WIDTH-1];
          end
          default: begin
            acc_d   = {acc_q[0], acc_q[WIDTH-1:1]};
            carry_d = acc_q[0];
          end
        endcase
        cnt_d = cnt_q - ONE;
        if (cnt_q == ONE) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    zero_d = writesAcc ? (acc_d == '0) : zero_q;
  end

  // State, counter and flag registers; reset drops any shift in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shOp_q  <= OP_NOP;
      acc_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shOp_q  <= shOp_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
    end
  end

  assign bus.ready   = (state_q == IDLE);
  assign bus.done    = done_q;
  assign bus.acc_out = acc_q;
  assign bus.carry   = carry_q;
  assign bus.zero    = zero_q;

endmodule

// File: tb/tb_lipsi_acc_alu.sv
// ---------------------------------------------------------------------------
// tb_lipsi_acc_alu
// Self-checking bench for lipsi_acc_alu (WIDTH=8). Every accepted op pushes
// its expected acc/carry/zero onto a scoreboard; a monitor pops and compares
// whenever done is seen. Hand-written sequences cover reset during a shift,
// the busy handshake and back-to-back single-cycle ops.
// ---------------------------------------------------------------------------
module tb_lipsi_acc_alu;
  import lipsi_acc_pkg::*;

  logic clk = 1'b0;
  logic reset_n;

  // 10-unit clock period.
  always #5 clk = ~clk;

  lipsi_acc_alu_if #(.WIDTH(8)) bus();

  lipsi_acc_alu #(.WIDTH(8)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct {
    logic [3:0] op;
    logic [7:0] operand;
    logic [3:0] shamt;
    logic [7:0] acc;
    logic       carry;
    logic       zero;
  } vec_t;

  typedef struct {
    logic [7:0] acc;
    logic       carry;
    logic       zero;
    int         tag;
  } exp_t;

  exp_t sbQ[$];
  vec_t vecs[$];
  int   total   = 0;
  int   bad     = 0;
  int   tagNext = 0;

  // Single comparison point: counts it and reports a mismatch.
  task automatic checkOutput(input string name, input int tag,
                             input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s (op #%0d): got 0x%0h, expected 0x%0h", name, tag, act, exp);
    end
  endtask

  // Waits (bounded) for ready, then presents one op for exactly one edge and
  // records what the accumulator should hold once done appears.
  task automatic applyStimulus(input logic [3:0] o, input logic [7:0] d,
                               input logic [3:0] s, input logic [7:0] eAcc,
                               input logic eC, input logic eZ);
    int   waited = 0;
    exp_t e;
    @(negedge clk);
    while (!bus.ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.ready) checkOutput("ready_timeout", tagNext, 32'(bus.ready), 32'd1);
    bus.start   = 1'b1;
    bus.op      = o;
    bus.operand = d;
    bus.shamt   = s;
    e.acc   = eAcc;
    e.carry = eC;
    e.zero  = eZ;
    e.tag   = tagNext;
    tagNext++;
    sbQ.push_back(e);
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Shift with handshake checks: ready/done low for n cycles while junk
  // starts are offered, then ready and done high together.
  task automatic shiftCheck(input logic [3:0] o, input logic [3:0] s, input int n,
                            input logic [7:0] eAcc, input logic eC, input logic eZ);
    int t;
    applyStimulus(o, 8'h00, s, eAcc, eC, eZ);
    t = tagNext - 1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput("busy_ready", t, 32'(bus.ready), 32'd0);
      checkOutput("busy_done", t, 32'(bus.done), 32'd0);
      bus.start   = 1'b1;
      bus.op      = OP_LD;
      bus.operand = 8'hAA;
      bus.shamt   = 4'd0;
    end
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("end_ready", t, 32'(bus.ready), 32'd1);
    checkOutput("end_done", t, 32'(bus.done), 32'd1);
  endtask

  // Scoreboard monitor: each done pulse retires the oldest expectation.
  always @(negedge clk) begin
    if (reset_n && bus.done) begin
      if (sbQ.size() == 0) begin
        checkOutput("spurious_done", -1, 32'(bus.done), 32'd0);
      end else begin
        exp_t e;
        e = sbQ.pop_front();
        checkOutput("acc", e.tag, 32'(bus.acc_out), 32'(e.acc));
        checkOutput("carry", e.tag, 32'(bus.carry), 32'(e.carry));
        checkOutput("zero", e.tag, 32'(bus.zero), 32'(e.zero));
      end
    end
  end

  // Hard stop in case something hangs despite the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs.push_back('{OP_LD,  8'hF0, 4'd0,  8'hF0, 1'b0, 1'b0});
    vecs.push_back('{OP_ADD, 8'h20, 4'd0,  8'h10, 1'b1, 1'b0});
    vecs.push_back('{OP_ADC, 8'h00, 4'd0,  8'h11, 1'b0, 1'b0});
    vecs.push_back('{OP_LD,  8'h05, 4'd0,  8'h05, 1'b0, 1'b0});
    vecs.push_back('{OP_SUB, 8'h06, 4'd0,  8'hFF, 1'b1, 1'b0});
    vecs.push_back('{OP_SBC, 8'hFE, 4'd0,  8'h00, 1'b0, 1'b1});
    vecs.push_back('{OP_LD,  8'h81, 4'd0,  8'h81, 1'b0, 1'b0});
    vecs.push_back('{OP_ROL, 8'h00, 4'd1,  8'h03, 1'b1, 1'b0});
    vecs.push_back('{OP_LD,  8'h5A, 4'd0,  8'h5A, 1'b1, 1'b0});
    vecs.push_back('{OP_SHL, 8'h00, 4'd0,  8'h5A, 1'b1, 1'b0});
    vecs.push_back('{OP_ROR, 8'h00, 4'd15, 8'h5A, 1'b0, 1'b0});
    vecs.push_back('{OP_OR,  8'h0F, 4'd0,  8'h5F, 1'b0, 1'b0});
    vecs.push_back('{OP_NOP, 8'hFF, 4'd0,  8'h5F, 1'b0, 1'b0});
    vecs.push_back('{4'd14,  8'h00, 4'd0,  8'h5F, 1'b0, 1'b0});
    vecs.push_back('{OP_SHL, 8'h00, 4'd8,  8'h00, 1'b1, 1'b1});
    vecs.push_back('{OP_CLR, 8'h33, 4'd0,  8'h00, 1'b0, 1'b1});
    vecs.push_back('{OP_LD,  8'h80, 4'd0,  8'h80, 1'b0, 1'b0});
    vecs.push_back('{OP_SHR, 8'h00, 4'd9,  8'h00, 1'b1, 1'b1});
    vecs.push_back('{OP_LD,  8'h3C, 4'd0,  8'h3C, 1'b1, 1'b0});
    vecs.push_back('{OP_ROL, 8'h00, 4'd3,  8'hE1, 1'b1, 1'b0});
    vecs.push_back('{OP_ROR, 8'h00, 4'd2,  8'h78, 1'b0, 1'b0});
    vecs.push_back('{OP_AND, 8'hFF, 4'd0,  8'h78, 1'b0, 1'b0});
    vecs.push_back('{OP_LD,  8'h10, 4'd0,  8'h10, 1'b0, 1'b0});
    vecs.push_back('{OP_SUB, 8'h10, 4'd0,  8'h00, 1'b0, 1'b1});
    vecs.push_back('{OP_ADD, 8'hFF, 4'd0,  8'hFF, 1'b0, 1'b0});
    vecs.push_back('{OP_ADC, 8'h01, 4'd0,  8'h00, 1'b1, 1'b1});
    vecs.push_back('{OP_SBC, 8'h00, 4'd0,  8'hFF, 1'b1, 1'b0});
    vecs.push_back('{OP_SUB, 8'hFF, 4'd0,  8'h00, 1'b0, 1'b1});

    bus.start   = 1'b0;
    bus.op      = 4'd0;
    bus.operand = 8'h00;
    bus.shamt   = 4'd0;
    reset_n     = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    checkOutput("rst_acc", -1, 32'(bus.acc_out), 32'h00);
    checkOutput("rst_carry", -1, 32'(bus.carry), 32'd0);
    checkOutput("rst_zero", -1, 32'(bus.zero), 32'd1);
    checkOutput("rst_ready", -1, 32'(bus.ready), 32'd1);
    checkOutput("rst_done", -1, 32'(bus.done), 32'd0);
    reset_n = 1'b1;

    // Reset one step into SHL 3 of 0x81 (acc would be 0x02, carry 1).
    applyStimulus(OP_LD, 8'h81, 4'd0, 8'h81, 1'b0, 1'b0);
    applyStimulus(OP_SHL, 8'h00, 4'd3, 8'h08, 1'b0, 1'b0);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("midrst_acc", -1, 32'(bus.acc_out), 32'h00);
    checkOutput("midrst_carry", -1, 32'(bus.carry), 32'd0);
    checkOutput("midrst_zero", -1, 32'(bus.zero), 32'd1);
    checkOutput("midrst_ready", -1, 32'(bus.ready), 32'd1);
    checkOutput("midrst_done", -1, 32'(bus.done), 32'd0);
    sbQ.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("postrst_ready", -1, 32'(bus.ready), 32'd1);
    checkOutput("postrst_done", -1, 32'(bus.done), 32'd0);
    checkOutput("postrst_acc", -1, 32'(bus.acc_out), 32'h00);

    // Table of single-cycle and shift ops.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, vecs[i].operand, vecs[i].shamt,
                    vecs[i].acc, vecs[i].carry, vecs[i].zero);
    end

    // Shift handshake with ignored starts while busy.
    applyStimulus(OP_LD, 8'h81, 4'd0, 8'h81, 1'b0, 1'b0);
    shiftCheck(OP_ROL, 4'd1, 1, 8'h03, 1'b1, 1'b0);
    shiftCheck(OP_SHR, 4'd4, 4, 8'h00, 1'b0, 1'b1);

    // Back-to-back single-cycle ops with carry held at 1.
    applyStimulus(OP_LD,  8'h00, 4'd0, 8'h00, 1'b0, 1'b1);
    applyStimulus(OP_SUB, 8'h01, 4'd0, 8'hFF, 1'b1, 1'b0);
    applyStimulus(OP_LD,  8'h0F, 4'd0, 8'h0F, 1'b1, 1'b0);
    applyStimulus(OP_AND, 8'h3C, 4'd0, 8'h0C, 1'b1, 1'b0);
    applyStimulus(OP_XOR, 8'h0C, 4'd0, 8'h00, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("b2b_done_last", -1, 32'(bus.done), 32'd1);
    @(negedge clk);
    checkOutput("b2b_done_drop", -1, 32'(bus.done), 32'd0);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", -1, 32'(sbQ.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
